axis_skid_slice: RTL

AXIS_SKID_SLICE -- requirements
Module: axis_skid_slice

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_beat_reg.sv | 39 +++
 rtl/axis_skid_slice.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared constants for the AXI-Stream register slice: mode selectors and
// the skid-buffer state encoding (the state value doubles as the beat count).
package axis_pkg;

  localparam int BYPASS = 0;
  localparam int FWD    = 1;
  localparam int SKID   = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic logic [1:0] state_count(skid_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axis_beat_reg.sv
// One AXI-Stream beat {data, keep, last} held in flops.
// Reset and clear both zero the beat; load captures a new beat.
module axis_beat_reg #(
  parameter int DW = 32,
  parameter int KW = DW/8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d_data,
  input  logic [KW-1:0] d_keep,
  input  logic          d_last,
  output logic [DW-1:0] q_data,
  output logic [KW-1:0] q_keep,
  output logic          q_last
);

  logic [DW-1:0] data_reg;
  logic [KW-1:0] keep_reg;
  logic          last_reg;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      data_reg <= '0;
      keep_reg <= '0;
      last_reg <= 1'b0;
    end else if (load) begin
      data_reg <= d_data;
      keep_reg <= d_keep;
      last_reg <= d_last;
    end
  end

  assign q_data = data_reg;
  assign q_keep = keep_reg;
  assign q_last = last_reg;

endmodule

// File: rtl/axis_skid_slice.sv
// AXI-Stream register slice: bypass, forward-registered, or full skid buffer
// selected at elaboration by MODE.
module axis_skid_slice
  import axis_pkg::*;
#(
  parameter int DW   = 32,
  parameter int KW   = DW/8,
  parameter int MODE = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] s_axis_data,
  input  logic [KW-1:0] s_axis_keep,
  input  logic          s_axis_last,
  input  logic          s_axis_valid,
  output logic          s_axis_ready,
  output logic [DW-1:0] m_axis_data,
  output logic [KW-1:0] m_axis_keep,
  output logic          m_axis_last,
  output logic          m_axis_valid,
  input  logic          m_axis_ready,
  output logic [1:0]    occupancy
);

  generate
    if (DW < 8 || DW > 1024 || (DW % 8) != 0) begin : g_bad_dw
      $error("axis_skid_slice: DW=%0d must be a multiple of 8 in 8..1024", DW);
    end

    if (MODE == BYPASS) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ resetn;

      assign m_axis_data  = s_axis_data;
      assign m_axis_keep  = s_axis_keep;
      assign m_axis_last  = s_axis_last;
      assign m_axis_valid = s_axis_valid;
      assign s_axis_ready = m_axis_ready;
      assign occupancy    = 2'd0;

    end else if (MODE == FWD) begin : g_fwd
      logic valid_reg;
      logic in_fire;

      // Accept whenever the output register is free or being drained this cycle.
      assign s_axis_ready = m_axis_ready | ~valid_reg;
      assign in_fire      = s_axis_valid & s_axis_ready;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          valid_reg <= 1'b0;
        end else if (s_axis_ready) begin
          valid_reg <= s_axis_valid;
        end
      end

      axis_beat_reg #(.DW(DW), .KW(KW)) u_out_reg (
        .clk    (clk),
        .resetn (resetn),
        .load   (in_fire),
        .clear  (1'b0),
        .d_data (s_axis_data),
        .d_keep (s_axis_keep),
        .d_last (s_axis_last),
        .q_data (m_axis_data),
        .q_keep (m_axis_keep),
        .q_last (m_axis_last)
      );

      assign m_axis_valid = valid_reg;
      assign occupancy    = {1'b0, valid_reg};

    end else if (MODE == SKID) begin : g_skid
      skid_state_t   state_reg, state_next;
      logic          ready_reg;
      logic          in_fire, out_fire;
      logic          out_load, out_sel_skid, skid_load, skid_clear;
      logic [DW-1:0] skid_data, out_d_data;
      logic [KW-1:0] skid_keep, out_d_keep;
      logic          skid_last, out_d_last;

      assign in_fire  = s_axis_valid & ready_reg;
      assign out_fire = m_axis_valid & m_axis_ready;

      always_comb begin
        state_next   = state_reg;
        out_load     = 1'b0;
        out_sel_skid = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        case (state_reg)
          EMPTY: begin
            if (in_fire) begin
              state_next = ONE;
              out_load   = 1'b1;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              out_load = 1'b1;
            end else if (in_fire) begin
              state_next = TWO;
              skid_load  = 1'b1;
            end else if (out_fire) begin
              state_next = EMPTY;
            end
          end
          TWO: begin
            // ready_reg is low here, so only the drain path exists.
            if (out_fire) begin
              state_next   = ONE;
              out_load     = 1'b1;
              out_sel_skid = 1'b1;
              skid_clear   = 1'b1;
            end
          end
          default: state_next = EMPTY;
        endcase
      end

      // Ready is a pure flop: it is low through reset and the first cycle after.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          state_reg <= EMPTY;
          ready_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          ready_reg <= (state_next != TWO);
        end
      end

      assign out_d_data = out_sel_skid ? skid_data : s_axis_data;
      assign out_d_keep = out_sel_skid ? skid_keep : s_axis_keep;
      assign out_d_last = out_sel_skid ? skid_last : s_axis_last;

      axis_beat_reg #(.DW(DW), .KW(KW)) u_out_reg (
        .clk    (clk),
        .resetn (resetn),
        .load   (out_load),
        .clear  (1'b0),
        .d_data (out_d_data),
        .d_keep (out_d_keep),
        .d_last (out_d_last),
        .q_data (m_axis_data),
        .q_keep (m_axis_keep),
        .q_last (m_axis_last)
      );

      axis_beat_reg #(.DW(DW), .KW(KW)) u_skid_reg (
        .clk    (clk),
        .resetn (resetn),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_data (s_axis_data),
        .d_keep (s_axis_keep),
        .d_last (s_axis_last),
        .q_data (skid_data),
        .q_keep (skid_keep),
        .q_last (skid_last)
      );

      assign s_axis_ready = ready_reg;
      assign m_axis_valid = (state_reg != EMPTY);
      assign occupancy    = state_count(state_reg);

    end else begin : g_bad_mode
      $error("axis_skid_slice: MODE=%0d is not 0, 1 or 2", MODE);
      assign m_axis_data  = '0;
      assign m_axis_keep  = '0;
      assign m_axis_last  = 1'b0;
      assign m_axis_valid = 1'b0;
      assign s_axis_ready = 1'b0;
      assign occupancy    = 2'd0;
    end
  endgenerate

endmodule
